// File: rtl/serial_nibble_addsub_pkg.sv
// Shared constants for the nibble-serial add/subtract unit: FSM encodings,
// operation codes and the slice width.
package serial_nibble_addsub_pkg;

  localparam int NIBBLE_W = 4;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/serial_nibble_addsub_if.sv
// Start/done handshake and operand/result bus of the nibble-serial add/sub unit.
interface serial_nibble_addsub_if #(
  parameter int NIBBLES = 4
);

  logic                   start;
  logic [4*NIBBLES-1:0]   A;
  logic [4*NIBBLES-1:0]   B;
  logic                   op;
  logic                   busy;
  logic                   done;
  logic [4*NIBBLES-1:0]   Sum;
  logic                   overflow;
  logic                   carry_out;

  modport master (
    output start, A, B, op,
    input  busy, done, Sum, overflow, carry_out
  );

  modport slave (
    input  start, A, B, op,
    output busy, done, Sum, overflow, carry_out
  );

endinterface

// File: rtl/serial_nibble_addsub_slice.sv
// Combinational 4-bit add/subtract slice: four ripple full adders with B
// conditionally inverted; exposes the carry into and out of the MSB.
module nibble_addsub_slice
  import serial_nibble_addsub_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                sub,
  input  logic                cin,
  output logic [NIBBLE_W-1:0] s,
  output logic                c3,
  output logic                cout
);

  logic [NIBBLE_W-1:0] bx;
  logic [NIBBLE_W:0]   c;

  always_comb begin
    bx   = b ^ {NIBBLE_W{sub}};
    s    = '0;
    c    = '0;
    c[0] = cin;
    for (int i = 0; i < NIBBLE_W; i++) begin
      s[i]   = a[i] ^ bx[i] ^ c[i];
      c[i+1] = (a[i] & bx[i]) | (c[i] & (a[i] ^ bx[i]));
    end
    c3   = c[NIBBLE_W-1];
    cout = c[NIBBLE_W];
  end

endmodule

// File: rtl/serial_nibble_addsub.sv
// Multi-cycle W-bit add/subtract: one nibble per clock, LSB first, carry held
// between cycles; results are published only when the last nibble completes.
module serial_nibble_addsub
  import serial_nibble_addsub_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  serial_nibble_addsub_if.slave  bus
);

  localparam int W     = NIBBLE_W * NIBBLES;
  localparam int IDX_W = $clog2(NIBBLES);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIBBLES - 1);

  state_e             state_q, state_d;
  logic [W-1:0]       a_q, a_d;
  logic [W-1:0]       b_q, b_d;
  logic [W-1:0]       work_q, work_d;
  logic [W-1:0]       sum_q, sum_d;
  logic               op_q, op_d;
  logic               carry_q, carry_d;
  logic               ovf_q, ovf_d;
  logic               cout_q, cout_d;
  logic [IDX_W-1:0]   idx_q, idx_d;

  logic [NIBBLE_W-1:0] a_nib, b_nib, s_nib;
  logic                slice_c3, slice_cout;

  always_comb begin
    a_nib = a_q[int'(idx_q)*NIBBLE_W +: NIBBLE_W];
    b_nib = b_q[int'(idx_q)*NIBBLE_W +: NIBBLE_W];
  end

  nibble_addsub_slice u_slice (
    .a    (a_nib),
    .b    (b_nib),
    .sub  (op_q),
    .cin  (carry_q),
    .s    (s_nib),
    .c3   (slice_c3),
    .cout (slice_cout)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    work_d  = work_q;
    sum_d   = sum_q;
    op_d    = op_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    cout_d  = cout_q;
    idx_d   = idx_q;

    unique case (state_q)
      // DONE accepts start exactly like IDLE so operations can run back to back
      ST_IDLE, ST_DONE: begin
        if (bus.start) begin
          a_d     = bus.A;
          b_d     = bus.B;
          op_d    = bus.op;
          carry_d = (bus.op == OP_SUB);
          idx_d   = '0;
          work_d  = '0;
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        work_d[int'(idx_q)*NIBBLE_W +: NIBBLE_W] = s_nib;
        carry_d = slice_cout;
        idx_d   = idx_q + 1'b1;
        if (idx_q == IDX_LAST) begin
          sum_d   = work_d;
          cout_d  = slice_cout;
          ovf_d   = slice_c3 ^ slice_cout;
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      work_q  <= '0;
      sum_q   <= '0;
      op_q    <= 1'b0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      cout_q  <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      work_q  <= work_d;
      sum_q   <= sum_d;
      op_q    <= op_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
      cout_q  <= cout_d;
      idx_q   <= idx_d;
    end
  end

  assign bus.busy      = (state_q == ST_RUN);
  assign bus.done      = (state_q == ST_DONE);
  assign bus.Sum       = sum_q;
  assign bus.overflow  = ovf_q;
  assign bus.carry_out = cout_q;

endmodule

// File: doc/serial_nibble_addsub.md
Name: serial_nibble_addsub

Overview:
Multi-cycle add/subtract unit for operands wider than 4 bits. It processes one 4-bit nibble per clock through a 4-bit add/sub slice, LSB nibble first, and carries between cycles in a register. It sits directly upstream of the 4-bit adder datapath level and reuses the same two's-complement convention: op=0 is add, op=1 is subtract via B inversion plus carry-in. Results feed the lab's display/readout stage through a start/done handshake.

Parameters:
NIBBLES, 4, number of 4-bit nibbles per operand; operand width W = 4*NIBBLES; legal range 2..8.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous, active-high reset
start  input  1  request a new operation; sampled each rising edge
A  input  W  operand A, sampled only on the accepted-start edge
B  input  W  operand B, sampled only on the accepted-start edge
op  input  1  0 = A+B, 1 = A-B; sampled only on the accepted-start edge
busy  output  1  high while an operation is in progress
done  output  1  one-cycle pulse when Sum/overflow/carry_out are updated
Sum  output  W  result, two's complement, modulo 2^W
overflow  output  1  signed overflow of the full W-bit result
carry_out  output  1  carry out of the MSB; for subtract, 1 = no borrow

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Reset: on any edge with rst=1: state=IDLE, busy=0, done=0, Sum=0, overflow=0, carry_out=0, internal index/carry/operand registers cleared. rst has priority over start. Asserting rst mid-operation aborts it, and no done pulse is issued.
- States: IDLE, RUN, DONE.
  - IDLE: if start=1, latch A, B and op; carry_reg=op; idx=0; go to RUN; busy=1 from the next cycle.
  - RUN: each edge computes slice idx as a_nib + (b_nib XOR {4{op}}) + carry_reg. It writes the 4-bit sum into the working register at nibble idx, sets carry_reg to the slice carry-out, and increments idx.
  - RUN, last nibble: on the edge processing idx=NIBBLES-1, publish the working register to Sum, set carry_out to the slice cout, and set overflow to c3 XOR c4 of that slice (carry into MSB XOR carry out of MSB). Go to DONE with done=1 and busy=0.
  - DONE: lasts exactly one cycle, with done=1. If start=1 in DONE, it is accepted like IDLE (back-to-back allowed) and goes to RUN. Otherwise go to IDLE.
- Latency: with start accepted at edge t, done=1 during the cycle following edge t+NIBBLES. busy=1 for exactly NIBBLES cycles.
- start while busy (RUN) is ignored and not queued. A, B and op changing during RUN have no effect.
- Sum, overflow and carry_out hold their last published values until the next completion; they are not updated nibble-by-nibble.
- Width rules: all arithmetic is modulo 2^W. Subtracting the most negative value follows two's-complement wrap, and the overflow flag reports it.

Decomposition:
- Shared package/header: ST_IDLE, ST_RUN and ST_DONE state encodings (2 bits), OP_ADD=0, OP_SUB=1, and the NIBBLE_W=4 constant.
- One sub-module, nibble_addsub_slice. It is combinational, with inputs a[3:0], b[3:0], sub, cin and outputs s[3:0], c3, cout. It is built from four full-adder cells in a ripple chain with b XOR sub. The top level owns the FSM, index counter, carry register and result registers.

Test Plan:
- NIBBLES=4, A=0x1234, B=0x0FFF, op=0, start 1 cycle -> busy high 4 cycles, done pulse 4 cycles after acceptance; Sum=0x2233, overflow=0, carry_out=0.
- A=0x7FFF, B=0x0001, op=0 -> Sum=0x8000, overflow=1, carry_out=0; A=0xFFFF, B=0x0001, op=0 -> Sum=0x0000, overflow=0, carry_out=1.
- A=0x0000, B=0x0001, op=1 -> Sum=0xFFFF, overflow=0, carry_out=0 (borrow); A=0x8000, B=0x0001, op=1 -> Sum=0x7FFF, overflow=1, carry_out=1.
- Pulse start again 2 cycles into RUN with different A/B -> ignored; the first result is unchanged. Then assert start during the done cycle -> second operation accepted, and its done arrives exactly 4 cycles later.
- Assert rst for 1 cycle in mid-RUN -> all outputs 0, no done pulse. A following start with A=0x0005, B=0x0003, op=1 -> Sum=0x0002, carry_out=1.
- Randomised: 1000 operations for NIBBLES=2 and NIBBLES=8 against a W-bit reference model (sum, carry, signed overflow).
